uart_key_transmitter: RTL and testbench
=======================================

Name: uart_key_transmitter

Overview:
- Transmit-side counterpart of the keyboard-to-switch UART receiver.
- Watches 8 key/switch inputs. On each rising edge of a key, it queues and sends that key's ASCII character over a UART line (8N1, LSB first).
- Key map: keys[7..0] = 'a','s','d','f','z','x','c','v' (0x61,0x73,0x64,0x66,0x7a,0x78,0x63,0x76).
- The output drives the same serial protocol the receiver decodes, so board switches can loop back into, or be echoed to, a host terminal.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD_HZ, 9600, serial bit rate.
- CLKS_PER_BIT, CLK_HZ/BAUD_HZ (integer division, derived localparam), clocks per serial bit; must be >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- keys  input  8  asynchronous key/switch levels; bit i maps to the character above.
- uart_out  output  1  serial transmit line, idle high.
- busy  output  1  high while a frame (start to stop) is being sent.
- pending  output  8  queued key requests not yet started.

Behaviour:
- Reset (async, rst_n=0): uart_out=1, busy=0, pending=0, FSM=IDLE, counters=0. Synchronizer flops reset to 0, so keys already high at reset release produce an edge one sync delay later.
- Input path: 2-flop synchronizer per key, then a registered previous value. rise[i] = sync[i] & ~prev[i].
- Queue: pending[i] is set on rise[i] and cleared in the cycle its frame leaves IDLE. If set and clear hit the same bit in the same cycle, set wins and the new press is queued again. Repeated rises while pending collapse into one request.
- Arbitration: in IDLE with pending != 0, select the highest set index ('a' first). Load its byte into the shift register and go to START.
- FSM:
  - IDLE: uart_out=1, busy=0.
  - START: uart_out=0 for CLKS_PER_BIT clocks.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT clocks; a 3-bit bit index is used.
  - STOP: uart_out=1 for CLKS_PER_BIT clocks, then IDLE.
- busy=1 in START, DATA and STOP.
- Baud counter runs 0..CLKS_PER_BIT-1 and reloads to 0 at every state/bit boundary.
- uart_out is driven from a register (glitch-free).
- Frame length: exactly 10*CLKS_PER_BIT clocks.
- Back-to-back frames: if pending is nonzero at the end of STOP, spend one IDLE cycle, then START. The inter-frame gap is CLKS_PER_BIT+1 high clocks, counting the stop bit.
- Latency: keys[i] first sampled high at edge n gives pending[i]=1 after edge n+3. uart_out falls after edge n+4, provided the FSM is idle.
- Reset mid-frame: the line returns high immediately and the queue is lost.

Optional Feature:
- Macro: UART_KEY_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between DATA and STOP in a PARITY state lasting CLKS_PER_BIT. Frame becomes 11*CLKS_PER_BIT.
- Undefined: 8N1 only; the PARITY state and its logic are absent.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - key character constants KEY_A..KEY_V;
  - function clks_per_bit(clk_hz, baud_hz).
- The receiver shares the same character constants.
- Sub-module uart_tx_byte: byte serializer with start/data_in/busy handshake. start is accepted only when not busy; data is latched on accept.
- The top level holds the synchronizer, edge detect, pending register and priority arbiter.

Test Plan:
- Bench parameters: CLK_HZ=1_000_000, BAUD_HZ=100_000, so CLKS_PER_BIT=10.
- Reset: hold rst_n=0 with keys=0xFF -> uart_out=1, busy=0, pending=0. Release reset -> pending becomes 0xFF 3 clocks after the first sampling edge.
- Single key: pulse keys[7] -> uart_out low 10 clks, then bits 1,0,0,0,0,1,1,0 at 10 clks each, then high. busy high exactly 100 clks; pending[7] clears at frame start.
- Simultaneous keys: raise keys[0] and keys[5] together -> 0x64 ('d') frame, then 0x76 ('v') frame. Gap of 11 high clocks between the frame starts' preceding stops; 2x100 busy clocks.
- Re-press during send: toggle keys[3] low-high while its own frame is in DATA -> pending[3]=1 again, and a second 0x7a frame follows.
- Async reset mid-frame: assert rst_n during DATA bit 4 -> uart_out=1 and busy=0 within the same cycle (asynchronous), with no further frames.
- Parity build: define UART_KEY_TX_PARITY_EN and send 0x61 -> parity bit 1 before stop; frame is 110 clks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the key transmitter (and its matching receiver).
// Holds the serializer state encoding, the key-to-ASCII character constants,
// and helpers for the baud divisor and key index lookup.
package uart_pkg;

    localparam int unsigned NUM_KEYS  = 8;
    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [DATA_BITS-1:0] KEY_A = 8'h61;
    localparam logic [DATA_BITS-1:0] KEY_S = 8'h73;
    localparam logic [DATA_BITS-1:0] KEY_D = 8'h64;
    localparam logic [DATA_BITS-1:0] KEY_F = 8'h66;
    localparam logic [DATA_BITS-1:0] KEY_Z = 8'h7a;
    localparam logic [DATA_BITS-1:0] KEY_X = 8'h78;
    localparam logic [DATA_BITS-1:0] KEY_C = 8'h63;
    localparam logic [DATA_BITS-1:0] KEY_V = 8'h76;

    // Clocks per serial bit (integer division); callers must keep it >= 2.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud_hz);
        return clk_hz / baud_hz;
    endfunction

    // keys[7..0] map to 'a','s','d','f','z','x','c','v'.
    function automatic logic [DATA_BITS-1:0] key_char(input logic [2:0] idx);
        logic [DATA_BITS-1:0] ch;
        case (idx)
            3'd7:    ch = KEY_A;
            3'd6:    ch = KEY_S;
            3'd5:    ch = KEY_D;
            3'd4:    ch = KEY_F;
            3'd3:    ch = KEY_Z;
            3'd2:    ch = KEY_X;
            3'd1:    ch = KEY_C;
            default: ch = KEY_V;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/uart_key_transmitter_if.sv
// Pin-level bundle of the key transmitter.
//   keys     : asynchronous key/switch levels (driven by master)
//   uart_out : serial line, idle high (driven by slave)
//   busy     : frame in progress (driven by slave)
//   pending  : queued key requests not yet started (driven by slave)
interface uart_key_transmitter_if;

    logic [7:0] keys;
    logic       uart_out;
    logic       busy;
    logic [7:0] pending;

    modport master (output keys, input uart_out, input busy, input pending);
    modport slave  (input keys, output uart_out, output busy, output pending);

endinterface

// File: rtl/uart_tx_byte.sv
// Byte serializer: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Optional feature macro: UART_KEY_TX_PARITY_EN (adds a PARITY state before STOP).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start      : request; accepted only while idle, data_in latched on accept
//   data_in    : byte to send
//   busy       : registered, high from START through STOP
//   tx         : registered serial line, idle high
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 busy,
    output logic                 tx
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [2:0]           bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic                 tx_nxt;
    logic                 busy_nxt;
`ifdef UART_KEY_TX_PARITY_EN
    logic                 par, par_nxt;
`endif

    // State and datapath registers; line forced high on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
`ifdef UART_KEY_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
            tx      <= tx_nxt;
            busy    <= busy_nxt;
`ifdef UART_KEY_TX_PARITY_EN
            par     <= par_nxt;
`endif
        end
    end

    // Next-state logic; tx_nxt is the line level for the cycle after the edge.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        tx_nxt      = tx;
`ifdef UART_KEY_TX_PARITY_EN
        par_nxt     = par;
`endif
        case (state)
            IDLE: begin
                tx_nxt      = 1'b1;
                cnt_nxt     = '0;
                bit_idx_nxt = '0;
                if (start) begin
                    state_nxt = START;
                    shift_nxt = data_in;
                    tx_nxt    = 1'b0;
`ifdef UART_KEY_TX_PARITY_EN
                    par_nxt   = ^data_in;
`endif
                end
            end
            START: begin
                if (cnt == CNT_MAX) begin
                    cnt_nxt   = '0;
                    state_nxt = DATA;
                    tx_nxt    = shift[0];
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_MAX) begin
                    cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
`ifdef UART_KEY_TX_PARITY_EN
                        state_nxt = PARITY;
                        tx_nxt    = par;
`else
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        shift_nxt   = {1'b0, shift[DATA_BITS-1:1]};
                        tx_nxt      = shift[1];
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
`ifdef UART_KEY_TX_PARITY_EN
            PARITY: begin
                if (cnt == CNT_MAX) begin
                    cnt_nxt   = '0;
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (cnt == CNT_MAX) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: rtl/uart_key_transmitter.sv
// Key-to-UART transmitter: each rising key edge queues that key's ASCII
// character, which is sent as a serial frame (8N1, or 8E1 when
// UART_KEY_TX_PARITY_EN is defined). Highest key index is served first.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus.keys   : asynchronous key levels (bit 7 = 'a' ... bit 0 = 'v')
//   bus.uart_out, bus.busy, bus.pending : registered outputs
module uart_key_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned BAUD_HZ = 9600
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_key_transmitter_if.slave  bus
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD_HZ);

    logic [NUM_KEYS-1:0]  sync1, sync2, prev, rise_q, pending_q;
    logic [NUM_KEYS-1:0]  clr_c;
    logic [2:0]           sel_c;
    logic                 start_c;
    logic [DATA_BITS-1:0] data_c;
    logic                 tx_busy;
    logic                 tx_line;

    // Two-flop synchronizer, previous-value flop and registered rising-edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            prev   <= '0;
            rise_q <= '0;
        end else begin
            sync1  <= bus.keys;
            sync2  <= sync1;
            prev   <= sync2;
            rise_q <= sync2 & ~prev;
        end
    end

    // Priority arbiter: highest pending index wins when the serializer is idle.
    always_comb begin
        sel_c = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            if (pending_q[i]) sel_c = 3'(i);
        end
        start_c = (|pending_q) && !tx_busy;
        clr_c   = start_c ? (8'b1 << sel_c) : '0;
        data_c  = key_char(sel_c);
    end

    // Request queue; a new edge on a bit being cleared re-queues it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_c) | rise_q;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_c),
        .data_in (data_c),
        .busy    (tx_busy),
        .tx      (tx_line)
    );

    assign bus.uart_out = tx_line;
    assign bus.busy     = tx_busy;
    assign bus.pending  = pending_q;

endmodule

// File: tb/tb_uart_key_transmitter.sv
// Scoreboard bench for uart_key_transmitter (CLKS_PER_BIT = 10).
module tb_uart_key_transmitter;

    localparam int C = 10;
`ifdef UART_KEY_TX_PARITY_EN
    localparam int FRAME = 11 * C;
`else
    localparam int FRAME = 10 * C;
`endif

    // Reference key map, index = key bit.
    localparam logic [7:0] KEY_MAP [8] = '{8'h76, 8'h63, 8'h78, 8'h7a,
                                           8'h66, 8'h64, 8'h73, 8'h61};

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [7:0] sb [$];
    int         start_times [$];

    uart_key_transmitter_if bus ();

    uart_key_transmitter #(
        .CLK_HZ  (1_000_000),
        .BAUD_HZ (100_000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected frames for a simultaneous press: descending key index.
    task automatic push_mask(input logic [7:0] mask);
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) sb.push_back(KEY_MAP[i]);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d expected=0 frames outstanding", sb.size());
            sb.delete();
        end
        tick(3);
    endtask

    // Monitor: decode each frame from the line and compare with the scoreboard.
    logic       mon_prev = 1'b1;
    logic       mon_abort;
    logic [7:0] mon_data;
    logic       mon_start, mon_par, mon_stop, mon_busy_last, mon_busy_after, mon_line_after;
    logic [7:0] mon_exp;

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (rst_n !== 1'b1) begin
                mon_prev = 1'b1;
            end else if (mon_prev === 1'b1 && bus.uart_out === 1'b0) begin
                start_times.push_back(cyc);
                mon_abort = 1'b0;
                mon_data  = '0;
                mon_par   = 1'b0;
                mon_start = 1'b1;
                mon_stop  = 1'b0;
                mon_busy_last  = 1'b0;
                mon_busy_after = 1'b1;
                mon_line_after = 1'b0;
                for (int c = 1; c <= FRAME; c++) begin
                    @(posedge clk);
                    #1;
                    if (rst_n !== 1'b1) begin
                        mon_abort = 1'b1;
                        break;
                    end
                    if (c == C / 2) mon_start = bus.uart_out;
                    for (int k = 0; k < 8; k++) begin
                        if (c == C + k * C + C / 2) mon_data[k] = bus.uart_out;
                    end
                    if (c == 9 * C + C / 2) mon_par = bus.uart_out;
                    if (c == FRAME - C + C / 2) mon_stop = bus.uart_out;
                    if (c == FRAME - 1) mon_busy_last = bus.busy;
                    if (c == FRAME) begin
                        mon_busy_after = bus.busy;
                        mon_line_after = bus.uart_out;
                    end
                end
                if (!mon_abort) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame actual=%0h expected=none", mon_data);
                    end else begin
                        mon_exp = sb.pop_front();
                        check("frame_data", 32'(mon_data), 32'(mon_exp));
                        check("start_bit", 32'(mon_start), 32'd0);
`ifdef UART_KEY_TX_PARITY_EN
                        check("parity_bit", 32'(mon_par), 32'($countones(mon_exp) % 2));
`endif
                        check("stop_bit", 32'(mon_stop), 32'd1);
                        check("busy_last_cycle", 32'(mon_busy_last), 32'd1);
                        check("busy_after_frame", 32'(mon_busy_after), 32'd0);
                        check("line_after_frame", 32'(mon_line_after), 32'd1);
                    end
                end
                mon_prev = 1'b1;
            end else begin
                mon_prev = bus.uart_out;
            end
        end
    end

    logic [7:0] mask;
    int         n_starts;

    initial begin : stimulus
        rst_n    = 1'b0;
        bus.keys = 8'hFF;
        tick(3);
        check("reset_uart_out", 32'(bus.uart_out), 32'd1);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_pending", 32'(bus.pending), 32'd0);

        // Keys held through reset produce edges after release.
        push_mask(8'hFF);
        rst_n = 1'b1;
        tick(1);
        tick(2);
        check("rel_pending_n2", 32'(bus.pending), 32'h00);
        tick(1);
        check("rel_pending_n3", 32'(bus.pending), 32'hFF);
        tick(1);
        check("rel_pending_n4", 32'(bus.pending), 32'h7F);
        check("rel_line_n4", 32'(bus.uart_out), 32'd0);
        bus.keys = 8'h00;
        wait_drain(9 * FRAME + 100);

        // Single key 'a'.
        bus.keys = 8'h80;
        sb.push_back(8'h61);
        tick(1);
        tick(2);
        check("single_pending_n2", 32'(bus.pending), 32'h00);
        tick(1);
        check("single_pending_n3", 32'(bus.pending), 32'h80);
        tick(1);
        check("single_pending_n4", 32'(bus.pending), 32'h00);
        check("single_line_n4", 32'(bus.uart_out), 32'd0);
        check("single_busy_n4", 32'(bus.busy), 32'd1);
        tick(5);
        bus.keys = 8'h00;
        wait_drain(2 * FRAME + 50);

        // Simultaneous 'd' and 'v': back-to-back frames one idle cycle apart.
        start_times.delete();
        bus.keys = 8'h21;
        push_mask(8'h21);
        tick(6);
        bus.keys = 8'h00;
        wait_drain(3 * FRAME + 50);
        check("simul_frames", 32'(start_times.size()), 32'd2);
        if (start_times.size() == 2)
            check("simul_gap", 32'(start_times[1] - start_times[0]), 32'(FRAME + 1));

        // Re-press 'z' while its own frame is in DATA.
        bus.keys = 8'h08;
        sb.push_back(8'h7a);
        sb.push_back(8'h7a);
        tick(1);
        tick(29);
        bus.keys = 8'h00;
        tick(3);
        bus.keys = 8'h08;
        tick(6);
        check("repress_pending", 32'(bus.pending[3]), 32'd1);
        check("repress_busy", 32'(bus.busy), 32'd1);
        bus.keys = 8'h00;
        wait_drain(3 * FRAME + 50);

        // Randomized batches pressed while idle.
        for (int it = 0; it < 6; it++) begin
            mask = 8'($urandom_range(1, 255));
            bus.keys = mask;
            push_mask(mask);
            tick($urandom_range(2, 20));
            bus.keys = 8'h00;
            wait_drain(9 * FRAME + 100);
            tick($urandom_range(1, 30));
        end

        // Asynchronous reset during DATA bit 4 of 'a'.
        bus.keys = 8'h80;
        tick(1);
        tick(56);
        check("midframe_bit4_low", 32'(bus.uart_out), 32'd0);
        n_starts = start_times.size();
        #2;
        rst_n    = 1'b0;
        bus.keys = 8'h00;
        #1;
        check("async_rst_line", 32'(bus.uart_out), 32'd1);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_pending", 32'(bus.pending), 32'd0);
        tick(5);
        rst_n = 1'b1;
        tick(3 * FRAME);
        check("post_rst_no_frames", 32'(start_times.size()), 32'(n_starts));
        check("post_rst_line", 32'(bus.uart_out), 32'd1);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
